// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and stall-bus patterns for the pipeline stall controller.
// The stall bus is [0]pc [1]if [2]id [3]ex [4]mem [5]wb, where 1 means hold.
package pipe_stall_ctrl_pkg;

   localparam int STALL_BUS = 6;

   typedef enum logic [1:0] {
      PC_RUN   = 2'd0,
      PC_LU    = 2'd1,
      PC_FPEND = 2'd2,
      PC_FLUSH = 2'd3
   } pc_state_t;

   localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_BUS-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

   // Deepest requesting stage wins; shallower requests are subsumed.
   function automatic logic [STALL_BUS-1:0] stall_pattern(input logic req_if, input logic req_id,
                                                          input logic req_ex, input logic req_mem);
      if (req_mem)     return STALL_MEM;
      else if (req_ex) return STALL_EX;
      else if (req_id) return STALL_ID;
      else if (req_if) return STALL_IF;
      else             return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_lu_bubble_timer.sv
// Load-use bubble timer: 3-bit down-counter with load, freeze and clear.
// o_done pulses in the cycle the final bubble is consumed.
module lu_bubble_timer (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_load,
   input  logic [2:0] i_load_val,
   input  logic       i_freeze,
   input  logic       i_clear,
   output logic       o_busy,
   output logic       o_done
);

   logic [2:0] r_cnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= 3'd0;
      end else if (i_clear) begin
         r_cnt <= 3'd0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (!i_freeze && r_cnt != 3'd0) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   assign o_busy = (r_cnt != 3'd0);
   assign o_done = (r_cnt == 3'd1) && !i_freeze && !i_clear && !i_load;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests and exception redirects into the stall bus,
// flush and new_pc. Optional perf counters are enabled with `PIPE_CTRL_PERF_EN.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int LU_BUBBLES = 1,
   parameter int STALL_W    = STALL_BUS
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               stallreq_if,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_mem,
   input  logic               excp_req,
   input  logic [31:0]        excp_target,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [15:0]        flush_count
`endif
);

   localparam logic [2:0] LU_LOAD = 3'(LU_BUBBLES);

   pc_state_t              r_state;
   logic                   r_id_prev;
   logic                   r_lu_done;
   logic [31:0]            r_target;
   logic                   r_flush;
   logic [31:0]            r_new_pc;

   logic                   w_redirect;
   logic                   w_arm;
   logic                   w_deep;
   logic                   w_lu_busy;
   logic                   w_lu_done;
   logic [STALL_BUS-1:0]   w_stall;

   assign w_deep     = stallreq_ex | stallreq_mem;
   assign w_redirect = excp_req && (r_state == PC_RUN || r_state == PC_LU);
   // Only a fresh edge arms the timer, and never in the cycle right after a load-use stall.
   assign w_arm      = (r_state == PC_RUN) && stallreq_id && !r_id_prev && !r_lu_done;

   lu_bubble_timer u_lu_timer (
      .clk        (clk),
      .resetn     (resetn),
      .i_load     (w_arm),
      .i_load_val (LU_LOAD),
      .i_freeze   (w_deep),
      .i_clear    (w_redirect),
      .o_busy     (w_lu_busy),
      .o_done     (w_lu_done)
   );

   always_comb begin
      w_stall = STALL_NONE;
      case (r_state)
         PC_FLUSH: w_stall = STALL_NONE;
         PC_FPEND: w_stall = STALL_MEM;
         PC_LU:    w_stall = stall_pattern(stallreq_if, w_lu_busy, stallreq_ex, stallreq_mem);
         default:  w_stall = stall_pattern(stallreq_if, 1'b0, stallreq_ex, stallreq_mem);
      endcase
   end

   assign stall  = resetn ? STALL_W'(w_stall) : '0;
   assign flush  = r_flush;
   assign new_pc = r_new_pc;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= PC_RUN;
         r_id_prev <= 1'b0;
         r_lu_done <= 1'b0;
         r_target  <= 32'd0;
         r_flush   <= 1'b0;
         r_new_pc  <= 32'd0;
      end else begin
         r_id_prev <= stallreq_id;
         r_flush   <= 1'b0;
         r_new_pc  <= 32'd0;
         case (r_state)
            PC_RUN, PC_LU: begin
               r_lu_done <= 1'b0;
               if (excp_req) begin
                  r_target <= excp_target;
                  if (stallreq_mem) begin
                     r_state <= PC_FPEND;
                  end else begin
                     r_state  <= PC_FLUSH;
                     r_flush  <= 1'b1;
                     r_new_pc <= excp_target;
                  end
               end else if (r_state == PC_RUN) begin
                  if (w_arm) r_state <= PC_LU;
               end else if (w_lu_done) begin
                  r_state   <= PC_RUN;
                  r_lu_done <= 1'b1;
               end
            end
            PC_FPEND: begin
               if (!stallreq_mem) begin
                  r_state  <= PC_FLUSH;
                  r_flush  <= 1'b1;
                  r_new_pc <= r_target;
               end
            end
            PC_FLUSH: begin
               r_state   <= PC_RUN;
               r_lu_done <= 1'b0;
            end
            default: r_state <= PC_RUN;
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [15:0] r_flush_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stall_cycles <= 32'd0;
         r_flush_count  <= 16'd0;
      end else begin
         if (w_stall != STALL_NONE && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (r_flush && r_flush_count != '1)               r_flush_count  <= r_flush_count + 16'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;
`else
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: load-use bubbles, deep-stall freeze, redirects, reset.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        s_if, s_id, s_ex, s_mem, excp;
   logic [31:0] tgt;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.LU_BUBBLES(1), .STALL_W(6)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .stallreq_if  (s_if),
      .stallreq_id  (s_id),
      .stallreq_ex  (s_ex),
      .stallreq_mem (s_mem),
      .excp_req     (excp),
      .excp_target  (tgt),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check this cycle's outputs against the current inputs, then advance one clock.
   task automatic step(input string tag, input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc);
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
      chk({tag, ".new_pc"}, new_pc, e_pc);
      $display("step %-8s in if=%b id=%b ex=%b mem=%b excp=%b | stall=%b flush=%b new_pc=%h",
               tag, s_if, s_id, s_ex, s_mem, excp, stall, flush, new_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_now(input string tag);
      #1;
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".flush"}, 32'(flush), 32'd0);
      chk({tag, ".new_pc"}, new_pc, 32'd0);
      $display("async  %-8s stall=%b flush=%b new_pc=%h", tag, stall, flush, new_pc);
   endtask

   initial begin
      resetn = 1'b0;
      s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0; excp = 1'b0; tgt = 32'd0;
      s_mem = 1'b1;
      #2;
      step("rst", 6'b000000, 1'b0, 32'd0);
      s_mem  = 1'b0;
      resetn = 1'b1;
      step("idle", 6'b000000, 1'b0, 32'd0);

      // Lone load-use: arm, one bubble, then masked while the request is still high
      s_id = 1'b1;
      step("lu0", 6'b000000, 1'b0, 32'd0);
      step("lu1", 6'b000111, 1'b0, 32'd0);
      step("lu2", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b0;
      step("lu3", 6'b000000, 1'b0, 32'd0);

      // EX busy during LU_STALL freezes the bubble timer
      s_id = 1'b1;
      step("lx0", 6'b000000, 1'b0, 32'd0);
      s_ex = 1'b1;
      for (int i = 0; i < 10; i++) step("lx_ex", 6'b001111, 1'b0, 32'd0);
      s_ex = 1'b0;
      step("lx_id", 6'b000111, 1'b0, 32'd0);
      step("lx_end", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b0;
      step("lx_idl", 6'b000000, 1'b0, 32'd0);

      // Priority encoding of plain requests
      s_if = 1'b1;
      step("p_if", 6'b000011, 1'b0, 32'd0);
      s_ex = 1'b1;
      step("p_ex", 6'b001111, 1'b0, 32'd0);
      s_mem = 1'b1;
      step("p_mem", 6'b011111, 1'b0, 32'd0);
      s_if = 1'b0; s_ex = 1'b0; s_mem = 1'b0;
      step("p_none", 6'b000000, 1'b0, 32'd0);

      // Immediate redirect; flush overrides an EX request in the flush cycle
      excp = 1'b1; tgt = 32'hBFC00380;
      step("ex0", 6'b000000, 1'b0, 32'd0);
      excp = 1'b0; tgt = 32'hDEADBEEF; s_ex = 1'b1;
      step("ex1", 6'b000000, 1'b1, 32'hBFC00380);
      step("ex2", 6'b001111, 1'b0, 32'd0);
      s_ex = 1'b0;
      step("ex3", 6'b000000, 1'b0, 32'd0);

      // Deferred redirect behind an outstanding MEM access; second request ignored
      s_mem = 1'b1; excp = 1'b1; tgt = 32'h80000180;
      step("fp0", 6'b011111, 1'b0, 32'd0);
      excp = 1'b0;
      step("fp1", 6'b011111, 1'b0, 32'd0);
      excp = 1'b1; tgt = 32'h12345678;
      step("fp2", 6'b011111, 1'b0, 32'd0);
      excp = 1'b0;
      step("fp3", 6'b011111, 1'b0, 32'd0);
      s_mem = 1'b0;
      step("fp4", 6'b011111, 1'b0, 32'd0);
      step("fp5", 6'b000000, 1'b1, 32'h80000180);
      step("fp6", 6'b000000, 1'b0, 32'd0);

      // Redirect during LU_STALL clears the bubble timer
      s_id = 1'b1;
      step("rl0", 6'b000000, 1'b0, 32'd0);
      excp = 1'b1; tgt = 32'hA0000000;
      step("rl1", 6'b000111, 1'b0, 32'd0);
      excp = 1'b0;
      step("rl2", 6'b000000, 1'b1, 32'hA0000000);
      step("rl3", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b0;
      step("rl4", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b1;
      step("rl5", 6'b000000, 1'b0, 32'd0);
      step("rl6", 6'b000111, 1'b0, 32'd0);
      step("rl7", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b0;
      step("rl8", 6'b000000, 1'b0, 32'd0);

      // Asynchronous reset in the middle of LU_STALL
      s_id = 1'b1;
      step("rs0", 6'b000000, 1'b0, 32'd0);
      s_ex = 1'b1;
      resetn = 1'b0;
      chk_now("rs_lu");
      s_id = 1'b0; s_ex = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      s_id = 1'b1;
      step("rs1", 6'b000000, 1'b0, 32'd0);
      step("rs2", 6'b000111, 1'b0, 32'd0);
      step("rs3", 6'b000000, 1'b0, 32'd0);
      s_id = 1'b0;
      step("rs4", 6'b000000, 1'b0, 32'd0);

      // Asynchronous reset in FLUSH_PEND drops the pending redirect
      s_mem = 1'b1; excp = 1'b1; tgt = 32'h55AA55AA;
      step("rf0", 6'b011111, 1'b0, 32'd0);
      excp = 1'b0;
      resetn = 1'b0;
      chk_now("rs_fp");
      s_mem = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      step("rf1", 6'b000000, 1'b0, 32'd0);
      step("rf2", 6'b000000, 1'b0, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      chk("perf_rst_sc", stall_cycles, 32'd0);
      chk("perf_rst_fc", 32'(flush_count), 32'd0);
      s_ex = 1'b1;
      for (int i = 0; i < 5; i++) step("pf_ex", 6'b001111, 1'b0, 32'd0);
      s_ex = 1'b0;
      excp = 1'b1; tgt = 32'h00000100;
      step("pf_e0", 6'b000000, 1'b0, 32'd0);
      excp = 1'b0;
      step("pf_f0", 6'b000000, 1'b1, 32'h00000100);
      excp = 1'b1; tgt = 32'h00000200;
      step("pf_e1", 6'b000000, 1'b0, 32'd0);
      excp = 1'b0;
      step("pf_f1", 6'b000000, 1'b1, 32'h00000200);
      chk("perf_sc", stall_cycles, 32'd5);
      chk("perf_fc", 32'(flush_count), 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
